i2si_frame_ctrl: RTL and testbench
==================================

// Module: i2si_frame_ctrl
// PURPOSE
//  Sequences the synchronized I2S input datapath. It consumes the synchronizer's i2si_sck_transition strobe plus
//  delayed i2si_sd/i2si_ws, aligns to the stereo frame and deserializes left and right words.
//  Each completed L/R pair is presented on a valid/ready interface to the downstream sample FIFO.
//  Overrun and framing faults are flagged as sticky status bits.
// PARAMETERS
//  DATA_W    24  output word width per channel (MSB-justified capture)
//  MAX_BITS  32  max sck bits per channel slot before framing error; bit counter width = $clog2(MAX_BITS+1)
// PORTS
//  clk                  in   1        master clock (single clock domain)
//  rst                  in   1        asynchronous, active-low reset
//  en                   in   1        1 = run; 0 = return to IDLE
//  i2si_sck_transition  in   1        one-clk strobe per sck rising edge; sd/ws sampled only here
//  i2si_sd              in   1        synchronized serial data
//  i2si_ws              in   1        synchronized word select (0 = left, 1 = right)
//  clr_err              in   1        one-clk pulse clears overrun and frame_err
//  out_left             out  DATA_W   left sample of pair
//  out_right            out  DATA_W   right sample of pair
//  out_valid            out  1        pair available
//  out_ready            in   1        downstream accepts pair when out_valid && out_ready at posedge clk
//  overrun              out  1        sticky: a completed pair was dropped
//  frame_err            out  1        sticky: slot exceeded MAX_BITS
//  locked               out  1        1 in states LEFT and RIGHT
// BEHAVIOUR
//  Reset (rst=0): state=IDLE; shift reg, bit count, ws_prev, out_left, out_right, out_valid, overrun,
//   frame_err and locked all 0.
//  Events are evaluated only on cycles with i2si_sck_transition=1 ("tick").
//  On every tick: edge = (i2si_ws != ws_prev); ws_prev <= i2si_ws.
//  FSM:
//   IDLE  -> SYNC when en=1.
//   SYNC  -> LEFT on a tick with a 1->0 ws edge. The bit at that tick is discarded, and the count is cleared.
//   LEFT  -> every tick shifts in sd. On a 0->1 edge, that tick's bit is the left LSB (included):
//            latch left word, clear the count, go to RIGHT.
//   RIGHT -> same accumulation. On a 1->0 edge, latch the right word, then publish the pair and go to LEFT.
//   Any state -> IDLE in the cycle after en=0. The shift reg and count are cleared.
//   out_valid/out_* are held until accepted; the sticky flags are held.
//  Word assembly (n = bits in slot incl. edge bit):
//   - shift MSB-first, only while count < DATA_W; count saturates at MAX_BITS+1.
//   - n >= DATA_W: word = first DATA_W bits received.
//   - n < DATA_W: word = received bits << (DATA_W-n), zero-filled.
//  Framing error: if count would exceed MAX_BITS without an edge, set frame_err, go to SYNC and drop the partial pair.
//  Output handshake:
//   - publishing sets out_valid=1 with both words one clk after the closing tick.
//   - out_valid drops the cycle after out_valid && out_ready.
//   - if a pair is published while out_valid=1 and out_ready=0, the new pair is dropped,
//     old data is kept, and overrun is set.
//   - if out_ready=1 in the same cycle as publish, accept the old pair, load the new one, and keep out_valid=1.
//   - simultaneous clr_err and new error: the set wins.
//   - the left word is buffered internally, so out_left never changes while out_valid=1.
//  Latency: closing ws edge tick -> out_valid = 1 clk.
// STRUCTURE
//  i2si_pkg: FSM state localparams (IDLE, SYNC, LEFT, RIGHT; 2-bit), default DATA_W/MAX_BITS.
//  Sub-module i2si_word_shifter: shift reg + saturating counter + justify-on-latch; the FSM and handshake stay in this block.
// TESTING
//  1. DATA_W=24, 24-bit slots, L=0xA5A5A5, R=0x5A5A5A, out_ready=1
//     -> one pair per frame with exact values; locked=1 after first 1->0 ws edge.
//  2. 32-bit slots, L bits = 0x123456FF
//     -> out_left=0x123456 (extra LSBs dropped); 16-bit slot 0xBEEF -> 0xBEEF00.
//  3. out_ready=0 across two frames
//     -> first pair held; overrun=1; second pair absent; clr_err pulse -> overrun=0.
//  4. ws held constant for 40 ticks in LEFT
//     -> frame_err=1, state=SYNC, no out_valid; recovers on next 1->0 edge.
//  5. en=0 mid-RIGHT slot, then re-enabled
//     -> IDLE next clk; partial pair discarded; the first output after re-enable is a full new frame.
//  6. rst asserted mid-word with out_valid=1
//     -> all outputs 0 immediately (async); ticks during reset ignored.

Source files
------------

// File: rtl/i2si_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2si_pkg
// Description : Shared definitions for the I2S input frame controller:
//               FSM state encoding and default word/slot sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package i2si_pkg;

  localparam int c_DEF_DATA_W   = 24;
  localparam int c_DEF_MAX_BITS = 32;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SYNC  = 2'd1;
  localparam logic [1:0] c_ST_LEFT  = 2'd2;
  localparam logic [1:0] c_ST_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = c_ST_IDLE,
    SYNC  = c_ST_SYNC,
    LEFT  = c_ST_LEFT,
    RIGHT = c_ST_RIGHT
  } state_t;

endpackage
`default_nettype wire

// File: rtl/i2si_word_shifter.sv
`default_nettype none
// ============================================================================
// Module      : i2si_word_shifter
// Description : MSB-first serial-to-parallel shifter with a saturating bit
//               counter. The 'word' output is the justified word including
//               the bit presented this cycle, so the owner can latch it on
//               the same tick that closes the slot.
// Ports       : clk, rst (async active-low)
//               clear  - synchronous clear of shift reg and count (priority)
//               shift  - accept sd this cycle
//               sd     - serial data bit
//               cnt    - bits received so far in this slot
//               word   - MSB-justified word including the current bit
// Revision    : 1.0 - initial release
// ============================================================================
module i2si_word_shifter
  import i2si_pkg::*;
#(
  parameter  int DATA_W   = c_DEF_DATA_W,
  parameter  int MAX_BITS = c_DEF_MAX_BITS,
  localparam int CNT_W    = $clog2(MAX_BITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic              sd,
  output logic [CNT_W-1:0]  cnt,
  output logic [DATA_W-1:0] word
);

  // DATA_W is expected to be no larger than MAX_BITS so it fits the counter.
  localparam logic [CNT_W-1:0] c_CNT_SAT    = CNT_W'(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] c_DATA_W_CNT = CNT_W'(DATA_W);

  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;

  always_comb begin
    w_cnt_next   = (r_cnt == c_CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
    // Bits beyond DATA_W are counted but not captured.
    w_shift_next = (r_cnt < c_DATA_W_CNT) ? {r_shift[DATA_W-2:0], sd} : r_shift;
    // Short slots are left-justified and zero-filled.
    if (w_cnt_next >= c_DATA_W_CNT) begin
      word = w_shift_next;
    end else begin
      word = w_shift_next << (c_DATA_W_CNT - w_cnt_next);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (shift) begin
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/i2si_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2si_frame_ctrl
// Description : Aligns to the I2S stereo frame on synchronized sck ticks,
//               deserializes left/right words and presents each completed
//               pair on a valid/ready interface. Sticky overrun and framing
//               error flags.
// Ports       : clk, rst (async active-low), en
//               i2si_sck_transition, i2si_sd, i2si_ws - synchronized I2S
//               clr_err - clears sticky flags (a simultaneous set wins)
//               out_left, out_right, out_valid, out_ready - pair handshake
//               overrun, frame_err, locked - status
// Revision    : 1.0 - initial release
// ============================================================================
module i2si_frame_ctrl
  import i2si_pkg::*;
#(
  parameter int DATA_W   = c_DEF_DATA_W,
  parameter int MAX_BITS = c_DEF_MAX_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              i2si_sck_transition,
  input  logic              i2si_sd,
  input  logic              i2si_ws,
  input  logic              clr_err,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              frame_err,
  output logic              locked
);

  localparam int               c_CNT_W   = $clog2(MAX_BITS + 1);
  localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_BITS);

  state_t              r_state;
  logic                r_ws_prev;
  logic                r_locked;
  logic [DATA_W-1:0]   r_left_buf;
  logic [DATA_W-1:0]   r_out_left;
  logic [DATA_W-1:0]   r_out_right;
  logic                r_out_valid;
  logic                r_overrun;
  logic                r_frame_err;

  logic                w_in_slot;
  logic                w_edge;
  logic                w_slot_tick;
  logic                w_latch;
  logic                w_ferr;
  logic                w_publish;
  logic                w_sh_clear;
  logic [c_CNT_W-1:0]  w_cnt;
  logic [DATA_W-1:0]   w_word;

  assign w_in_slot   = (r_state == LEFT) || (r_state == RIGHT);
  assign w_edge      = (i2si_ws != r_ws_prev);
  assign w_slot_tick = i2si_sck_transition & w_in_slot & en;
  assign w_latch     = w_slot_tick & w_edge;
  // Another bit without a ws edge would overflow the slot.
  assign w_ferr      = w_slot_tick & ~w_edge & (w_cnt == c_MAX_CNT);
  assign w_publish   = w_latch & (r_state == RIGHT);
  // Shifter only accumulates inside a slot; every slot boundary restarts it.
  assign w_sh_clear  = ~en | ~w_in_slot | w_latch | w_ferr;

  i2si_word_shifter #(
    .DATA_W   (DATA_W),
    .MAX_BITS (MAX_BITS)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .clear (w_sh_clear),
    .shift (w_slot_tick),
    .sd    (i2si_sd),
    .cnt   (w_cnt),
    .word  (w_word)
  );

  // Frame alignment FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_locked   <= 1'b0;
      r_ws_prev  <= 1'b0;
      r_left_buf <= '0;
    end else begin
      if (i2si_sck_transition) begin
        r_ws_prev <= i2si_ws;
      end
      if (!en) begin
        r_state  <= IDLE;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state  <= SYNC;
            r_locked <= 1'b0;
          end
          SYNC: begin
            // The bit at the aligning edge belongs to an unseen right slot.
            if (i2si_sck_transition && r_ws_prev && !i2si_ws) begin
              r_state  <= LEFT;
              r_locked <= 1'b1;
            end
          end
          LEFT: begin
            if (w_latch) begin
              r_left_buf <= w_word;
              r_state    <= RIGHT;
            end else if (w_ferr) begin
              r_state  <= SYNC;
              r_locked <= 1'b0;
            end
          end
          RIGHT: begin
            if (w_latch) begin
              r_state <= LEFT;
            end else if (w_ferr) begin
              r_state  <= SYNC;
              r_locked <= 1'b0;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output handshake and sticky status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_left  <= '0;
      r_out_right <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_publish) begin
        if (!r_out_valid || out_ready) begin
          // Slot is free, or the held pair is accepted this same cycle.
          r_out_left  <= r_left_buf;
          r_out_right <= w_word;
          r_out_valid <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_publish && r_out_valid && !out_ready) begin
        r_overrun <= 1'b1;
      end else if (clr_err) begin
        r_overrun <= 1'b0;
      end

      if (w_ferr) begin
        r_frame_err <= 1'b1;
      end else if (clr_err) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign out_left  = r_out_left;
  assign out_right = r_out_right;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign locked    = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_i2si_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2si_frame_ctrl
// Description : Self-checking bench for i2si_frame_ctrl. Stimulus pushes the
//               expected L/R pair into a queue; a monitor pops and compares
//               each pair the DUT hands over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2si_frame_ctrl;

  localparam int DATA_W   = 24;
  localparam int MAX_BITS = 32;

  logic              clk;
  logic              rst;
  logic              en;
  logic              tick;
  logic              sd;
  logic              ws;
  logic              clr_err;
  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;
  logic              frame_err;
  logic              locked;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];

  i2si_frame_ctrl #(
    .DATA_W   (DATA_W),
    .MAX_BITS (MAX_BITS)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .en                  (en),
    .i2si_sck_transition (tick),
    .i2si_sd             (sd),
    .i2si_ws             (ws),
    .clr_err             (clr_err),
    .out_left            (out_left),
    .out_right           (out_right),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .overrun             (overrun),
    .frame_err           (frame_err),
    .locked              (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every cycle a transfer happens, compare against the scoreboard.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pair actual=%h_%h required=none", out_left, out_right);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        if ({out_left, out_right} !== e) begin
          errors++;
          $display("FAIL pair actual=%h_%h required=%h_%h", out_left, out_right, e[47:24], e[23:0]);
        end
      end
    end
  end

  // One sck tick (one clk high), followed by one idle clk.
  task automatic do_tick(input logic w, input logic d);
    tick = 1'b1;
    ws   = w;
    sd   = d;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic preamble();
    do_tick(1'b1, 1'b0);
    do_tick(1'b0, 1'b0);
  endtask

  // ws switches on the LSB tick of each slot.
  task automatic send_frame(input logic [31:0] l, input int nl, input logic [31:0] r, input int nr);
    for (int i = nl - 1; i >= 0; i--) do_tick(i == 0, l[i]);
    for (int i = nr - 1; i >= 0; i--) do_tick(i != 0, r[i]);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; tick = 1'b0; sd = 1'b0; ws = 1'b0;
    clr_err = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {60'd0, out_valid, locked, overrun, frame_err}, 64'd0);
    chk("reset_data", {16'd0, out_left, out_right}, 64'd0);
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk); #1;

    // 1: 24-bit slots
    chk("unlocked_before_edge", {63'd0, locked}, 64'd0);
    preamble();
    chk("locked_after_edge", {63'd0, locked}, 64'd1);
    exp_q.push_back({24'hA5A5A5, 24'h5A5A5A});
    send_frame(32'hA5A5A5, 24, 32'h5A5A5A, 24);
    exp_q.push_back({24'hA5A5A5, 24'h5A5A5A});
    send_frame(32'hA5A5A5, 24, 32'h5A5A5A, 24);

    // 2: long and short slots
    exp_q.push_back({24'h123456, 24'hBEEF00});
    send_frame(32'h123456FF, 32, 32'h0000BEEF, 16);
    exp_q.push_back({24'hBEEF00, 24'hABCDEF});
    send_frame(32'h0000BEEF, 16, 32'h00ABCDEF, 24);

    // 3: overrun while held
    out_ready = 1'b0;
    exp_q.push_back({24'h13579B, 24'h2468AC});
    send_frame(32'h13579B, 24, 32'h2468AC, 24);
    send_frame(32'hFFFFFF, 24, 32'hEEEEEE, 24);
    chk("overrun_set", {63'd0, overrun}, 64'd1);
    chk("held_pair", {16'd0, out_left, out_right}, {16'd0, 24'h13579B, 24'h2468AC});
    pulse_clr();
    chk("overrun_cleared", {63'd0, overrun}, 64'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("valid_dropped_after_accept", {63'd0, out_valid}, 64'd0);

    // 4: framing error, ws stuck in LEFT
    for (int i = 0; i < 40; i++) do_tick(1'b0, i[0]);
    chk("frame_err_set", {63'd0, frame_err}, 64'd1);
    chk("unlocked_after_ferr", {63'd0, locked}, 64'd0);
    preamble();
    chk("relocked", {63'd0, locked}, 64'd1);
    exp_q.push_back({24'h0F0F0F, 24'hF0F0F0});
    send_frame(32'h0F0F0F, 24, 32'hF0F0F0, 24);
    pulse_clr();
    chk("frame_err_cleared", {63'd0, frame_err}, 64'd0);

    // 5: disable mid-RIGHT
    for (int i = 23; i >= 0; i--) do_tick(i == 0, 1'b1);
    for (int i = 0; i < 10; i++) do_tick(1'b1, 1'b1);
    en = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_disable", {63'd0, locked}, 64'd0);
    en = 1'b1;
    @(posedge clk); #1;
    preamble();
    exp_q.push_back({24'h3C3C3C, 24'hC3C3C3});
    send_frame(32'h3C3C3C, 24, 32'hC3C3C3, 24);

    // 6: async reset while a pair is held
    out_ready = 1'b0;
    send_frame(32'h111111, 24, 32'h222222, 24);
    chk("valid_before_reset", {63'd0, out_valid}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_flags", {60'd0, out_valid, locked, overrun, frame_err}, 64'd0);
    chk("async_reset_data", {16'd0, out_left, out_right}, 64'd0);
    @(posedge clk); #1;
    do_tick(1'b1, 1'b1);
    do_tick(1'b0, 1'b1);
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("after_reset_state", {62'd0, out_valid, locked}, 64'd0);

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
